intc: RTL and testbench
=======================

# intc

Processor-side interrupt controller that receives the switch-change `interrupt` / `interrupt_id` pulses from the I/O block and turns them into a held request/acknowledge handshake with the core. It latches events into a pending register and gates them with a mask. It picks the highest-priority source and tracks the in-service interrupt until the handler's return. The core reads and writes it through a small memory-mapped register window on the same `wEn`/`addr`/`dataIn`/`dataOut` bus used for I/O.

## Interface
- `NUM_SRC`, 17: number of interrupt ids tracked (ids 0..16).
- `STACK_DEPTH`, 4: in-service nesting depth (used only with `INTC_NESTING_EN`).

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `reset` input 1: synchronous, active-high reset.
- `interrupt` input 1: single-cycle event strobe from the I/O block.
- `interrupt_id` input 5: event id, valid while `interrupt`=1.
- `wEn` input 1: register write enable (block already selected by the address decoder).
- `addr` input 32: byte address; only `addr[3:2]` decoded.
- `dataIn` input 32: write data.
- `dataOut` output 32: combinational read data.
- `irq_req` output 1: interrupt request to the core.
- `irq_cause` output 5: id of the requested interrupt; stable while `irq_req`=1.
- `irq_ack` input 1: core takes the trap (1 cycle).
- `irq_done` input 1: handler return, i.e. mret (1 cycle).

## Operation
- PEND[16:0]: on `interrupt`=1 with id ≤ 16, `PEND[id]` <= 1. Id 17..31 is dropped and sets sticky `ERR`. Bits latch regardless of mask.
- MASK[16:0]: 1 = enabled.
- Priority among PEND&MASK: lowest nonzero id wins; id 0 has lowest priority.
- Register map, selected by `addr[3:2]`:
  - 0 PENDING: read `{15'b0,PEND}`; write-1-to-clear.
  - 1 MASK: read/write `[16:0]`.
  - 2 STATUS: read `{23'b0, ERR[8], depth[7:5], in_service_id[4:0]}`; any write clears `ERR`.
  - 3: reads 0; writes ignored.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if any PEND&MASK, latch winner into `irq_cause` and go to REQ.
  - REQ: `irq_req`=1. On `irq_ack`: clear `PEND[irq_cause]`, push `irq_cause` as in-service (depth+1), go to SERVICE. Changing the mask while in REQ does not retract the request.
  - SERVICE: on `irq_done`, pop (depth-1); go to IDLE if depth becomes 0, else stay in SERVICE.
- Ignored inputs: `irq_ack` outside REQ; `irq_done` outside SERVICE, or with depth 0.
- Simultaneous events: a set of a PEND bit beats a W1C or ack-clear of the same bit in the same cycle. A write to MASK takes effect for the next cycle's arbitration.
- `in_service_id` reads 0 when depth = 0.

## Timing
- Reset values: `irq_req`=0, `irq_cause`=0, `dataOut` reflects reset registers (PEND=0, MASK=17'h1FFFF, ERR=0, depth=0), state IDLE.
- `interrupt` at cycle N -> PEND bit visible at N+1 -> `irq_req`=1 at N+2 (IDLE, unmasked).
- `irq_ack` at cycle M -> `irq_req`=0 at M+1; PEND bit reads cleared at M+1.
- After `irq_done` returns to IDLE, the next request can assert 1 cycle later.
- `irq_req` and `irq_cause` are registered. `dataOut` is combinational from `addr`.
- Reset mid-handshake: everything returns to reset values the next cycle. Pending events are lost.

## Configuration
- `INTC_NESTING_EN` defined:
  - In SERVICE, if PEND&MASK holds a winner of strictly higher priority than the top in-service id and depth < `STACK_DEPTH`, go to REQ.
  - The ack pushes that winner.
  - `irq_done` pops back to the previous in-service id.
  - At depth = `STACK_DEPTH` there is no preemption.
- Not defined:
  - SERVICE never issues a new request; depth is at most 1.
  - The stack collapses to a single in-service register.

## Test plan
- Reset, then pulse `interrupt` with id 3 -> PENDING reads 0x8 next cycle; `irq_req`=1 with `irq_cause`=3 two cycles after the pulse; ack -> PENDING=0 and STATUS in_service=3, depth=1; done -> STATUS=0.
- Pulse ids 5 and 2 on consecutive cycles while idle -> first request reflects whichever arbitration sees first. After it is serviced, the remaining one is requested. With both pending at IDLE entry, cause=2 first.
- Write MASK=0x0, pulse id 4 -> no `irq_req`, PENDING=0x10. Write MASK=0x10 -> `irq_req`, cause 4. Write PENDING=0x10 before ack -> request still held until ack.
- Pulse id 20 -> STATUS `ERR`=1, no request. Write STATUS -> `ERR`=0.
- With `INTC_NESTING_EN`, id 6 in service, pulse id 1 -> request cause 1, ack -> depth 2; done -> in_service 6, depth 1. Without the macro, no request until done.
- Assert `reset` while in REQ -> next cycle `irq_req`=0, PEND=0, MASK=0x1FFFF.

Source files
------------

// File: rtl/intc_if.sv
// rtl/intc_if.sv - I/O-event, register-window and core handshake bundle for intc
interface intc_if;
  logic        interrupt;
  logic [4:0]  interrupt_id;
  logic        wEn;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        irq_req;
  logic [4:0]  irq_cause;
  logic        irq_ack;
  logic        irq_done;

  // Driver side: I/O block strobes, core register accesses and trap handshake
  modport master (
    output interrupt, interrupt_id, wEn, addr, dataIn, irq_ack, irq_done,
    input  dataOut, irq_req, irq_cause
  );

  // Controller side
  modport slave (
    input  interrupt, interrupt_id, wEn, addr, dataIn, irq_ack, irq_done,
    output dataOut, irq_req, irq_cause
  );
endinterface

// File: rtl/intc.sv
// rtl/intc.sv - interrupt controller: pending/mask latch, priority pick, req/ack handshake; nesting via INTC_NESTING_EN
module intc #(
  parameter int NUM_SRC     = 17,
  parameter int STACK_DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  intc_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  localparam logic [4:0] MAX_ID    = 5'(NUM_SRC - 1);
  localparam logic [2:0] DEPTH_CAP = 3'(STACK_DEPTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic               r_err;
  logic [2:0]         r_depth;
  logic [4:0]         r_cause;
  logic [4:0]         w_win;
  logic [4:0]         w_top_id;
  logic               w_any;
  logic               w_preempt;
  logic               w_load;
  logic               w_push;
  logic               w_pop;
  logic               w_wr_pend;
  logic               w_wr_mask;
  logic               w_wr_stat;
  logic               w_bad_id;
  logic               w_unused_bits;

  assign w_wr_pend = bus.wEn && (bus.addr[3:2] == 2'd0);
  assign w_wr_mask = bus.wEn && (bus.addr[3:2] == 2'd1);
  assign w_wr_stat = bus.wEn && (bus.addr[3:2] == 2'd2);
  assign w_bad_id  = bus.interrupt && (bus.interrupt_id > MAX_ID);
  assign w_active  = r_pend & r_mask;
  assign w_any     = |w_active;

  // Winner: lowest nonzero id among enabled pending bits; id 0 only when alone
  always_comb begin
    w_win = 5'd0;
    for (int i = NUM_SRC - 1; i >= 1; i--) begin
      if (w_active[i]) w_win = 5'(i);
    end
  end

`ifdef INTC_NESTING_EN
  // Smaller rank means more urgent; id 0 sits below every other id
  function automatic logic [4:0] rank(input logic [4:0] id);
    return (id == 5'd0) ? 5'(NUM_SRC) : id;
  endfunction

  // In-service ids packed as a shift stack, top of stack in the low 5 bits
  logic [5*STACK_DEPTH-1:0] r_stack;

  assign w_top_id  = (r_depth == 3'd0) ? 5'd0 : r_stack[4:0];
  assign w_preempt = w_any && (rank(w_win) < rank(w_top_id)) && (r_depth < DEPTH_CAP);

  // Push the acknowledged cause, pop back to the interrupted handler on return
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stack <= '0;
    end else if (w_push) begin
      r_stack <= {r_stack[5*STACK_DEPTH-6:0], r_cause};
    end else if (w_pop) begin
      r_stack <= {5'd0, r_stack[5*STACK_DEPTH-1:5]};
    end
  end

  assign w_unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.dataIn[31:NUM_SRC]};
`else
  // Without nesting only one handler can be active, so one id register suffices
  logic [4:0] r_is_id;

  assign w_top_id  = (r_depth == 3'd0) ? 5'd0 : r_is_id;
  assign w_preempt = 1'b0;

  // Capture the acknowledged cause; forget it when the handler returns
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_id <= 5'd0;
    end else if (w_push) begin
      r_is_id <= r_cause;
    end else if (w_pop) begin
      r_is_id <= 5'd0;
    end
  end

  assign w_unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.dataIn[31:NUM_SRC], DEPTH_CAP};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and handshake strobes; a return beats a preemption in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.irq_ack) begin
          w_push      = 1'b1;
          w_state_nxt = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (bus.irq_done && (r_depth != 3'd0)) begin
          w_pop = 1'b1;
          if (r_depth == 3'd1) w_state_nxt = S_IDLE;
        end else if (w_preempt) begin
          w_load      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-bit set/clear terms for the pending register
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_set[i] = bus.interrupt && (bus.interrupt_id == 5'(i));
      w_clr[i] = (w_wr_pend && bus.dataIn[i]) || (w_push && (r_cause == 5'(i)));
    end
  end

  // Pending, mask, error and depth registers; a new event outranks any clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= '0;
      r_mask  <= '1;
      r_err   <= 1'b0;
      r_depth <= 3'd0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_wr_mask) r_mask <= bus.dataIn[NUM_SRC-1:0];
      if (w_bad_id)       r_err <= 1'b1;
      else if (w_wr_stat) r_err <= 1'b0;
      if (w_push)     r_depth <= r_depth + 3'd1;
      else if (w_pop) r_depth <= r_depth - 3'd1;
    end
  end

  // Requested cause, frozen for as long as the request is held
  always_ff @(posedge clk) begin
    if (reset)       r_cause <= 5'd0;
    else if (w_load) r_cause <= w_win;
  end

  assign bus.irq_req   = (r_state == S_REQ);
  assign bus.irq_cause = r_cause;

  // Register window read mux
  always_comb begin
    bus.dataOut = 32'd0;
    case (bus.addr[3:2])
      2'd0:    bus.dataOut = 32'(r_pend);
      2'd1:    bus.dataOut = 32'(r_mask);
      2'd2:    bus.dataOut = {23'd0, r_err, r_depth, w_top_id};
      default: bus.dataOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - self-checking bench for intc with a queue-based reference model
module tb_intc;

  logic clk = 1'b0;
  logic reset;
  intc_if bus();

  intc dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef INTC_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] rdata;

  // Reference model: plain arrays plus a queue of in-service ids (back = current)
  bit m_pend [17];
  bit m_mask [17];
  bit m_err;
  bit m_req;
  int m_cause;
  int m_stack [$];

  function automatic int m_rank(input int id);
    return (id == 0) ? 100 : id;
  endfunction

  function automatic int m_winner();
    for (int i = 1; i < 17; i++) if (m_pend[i] && m_mask[i]) return i;
    if (m_pend[0] && m_mask[0]) return 0;
    return -1;
  endfunction

  function automatic logic [31:0] m_pend_word();
    logic [31:0] w = 0;
    for (int i = 0; i < 17; i++) if (m_pend[i]) w = w | (32'd1 << i);
    return w;
  endfunction

  function automatic logic [31:0] m_mask_word();
    logic [31:0] w = 0;
    for (int i = 0; i < 17; i++) if (m_mask[i]) w = w | (32'd1 << i);
    return w;
  endfunction

  function automatic logic [31:0] m_status();
    int top = (m_stack.size() == 0) ? 0 : m_stack[$];
    return (32'(m_err) << 8) | (32'(m_stack.size()) << 5) | 32'(top);
  endfunction

  // Apply one clock's worth of the controller's rules to the model
  task automatic m_step();
    int win;
    int ack_clr;
    int dummy;
    if (reset) begin
      for (int i = 0; i < 17; i++) begin m_pend[i] = 0; m_mask[i] = 1; end
      m_err = 0; m_req = 0; m_cause = 0; m_stack.delete();
      return;
    end
    win = m_winner();
    ack_clr = -1;
    if (m_req) begin
      if (bus.irq_ack) begin ack_clr = m_cause; m_stack.push_back(m_cause); m_req = 0; end
    end else if (m_stack.size() == 0) begin
      if (win >= 0) begin m_req = 1; m_cause = win; end
    end else if (bus.irq_done) begin
      dummy = m_stack.pop_back();
    end else if (NEST && win >= 0 && m_rank(win) < m_rank(m_stack[$]) && m_stack.size() < 4) begin
      m_req = 1; m_cause = win;
    end
    if (bus.wEn) begin
      case (bus.addr[3:2])
        2'd0: for (int i = 0; i < 17; i++) if (bus.dataIn[i]) m_pend[i] = 0;
        2'd1: for (int i = 0; i < 17; i++) m_mask[i] = bus.dataIn[i];
        2'd2: m_err = 0;
        default: ;
      endcase
    end
    if (ack_clr >= 0) m_pend[ack_clr] = 0;
    if (bus.interrupt) begin
      if (bus.interrupt_id <= 5'd16) m_pend[bus.interrupt_id] = 1;
      else m_err = 1;
    end
  endtask

  // One clock: model follows the edge, single-cycle strobes drop afterwards
  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    bus.interrupt = 1'b0;
    bus.irq_ack   = 1'b0;
    bus.irq_done  = 1'b0;
    bus.wEn       = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = {28'd0, a, 2'b00};
    #1;
    d = bus.dataOut;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wEn = 1'b1; bus.addr = {28'd0, a, 2'b00}; bus.dataIn = d;
    cycle();
  endtask

  task automatic pulse(input int id);
    bus.interrupt = 1'b1; bus.interrupt_id = 5'(id);
    cycle();
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1; cycle();
  endtask

  task automatic done();
    bus.irq_done = 1'b1; cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; cycle();
    reset = 1'b1; cycle();
    n_cmp++; if (bus.irq_req !== 1'b0 || bus.irq_cause !== 5'd0) begin n_fail++;
      $display("FAIL reset_req: req=%0b cause=%0d want 0/0", bus.irq_req, bus.irq_cause); end
    rd(0, rdata); n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", rdata); end
    rd(1, rdata); n_cmp++; if (rdata !== 32'h1FFFF) begin n_fail++; $display("FAIL reset_mask: got %h want 1ffff", rdata); end
    rd(2, rdata); n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", rdata); end
    rd(3, rdata); n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_reg3: got %h want 0", rdata); end
  endtask

  task automatic test_basic();
    pulse(3);
    rd(0, rdata); n_cmp++; if (rdata !== 32'h8 || bus.irq_req !== 1'b0) begin n_fail++;
      $display("FAIL basic_pend: pend=%h req=%0b want 8/0", rdata, bus.irq_req); end
    cycle();
    n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd3) begin n_fail++;
      $display("FAIL basic_req: req=%0b cause=%0d want 1/3", bus.irq_req, bus.irq_cause); end
    ack();
    rd(0, rdata); n_cmp++; if (rdata !== 32'h0 || bus.irq_req !== 1'b0) begin n_fail++;
      $display("FAIL basic_ack: pend=%h req=%0b want 0/0", rdata, bus.irq_req); end
    rd(2, rdata); n_cmp++; if (rdata !== 32'h23) begin n_fail++; $display("FAIL basic_status: got %h want 23", rdata); end
    done();
    rd(2, rdata); n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL basic_done: got %h want 0", rdata); end
  endtask

  task automatic test_arbitration();
    pulse(5); pulse(2);
    n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'(m_cause) || m_cause != 5) begin n_fail++;
      $display("FAIL arb_first: req=%0b cause=%0d want 1/5", bus.irq_req, bus.irq_cause); end
    ack(); done(); cycle();
    n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd2) begin n_fail++;
      $display("FAIL arb_second: req=%0b cause=%0d want 1/2", bus.irq_req, bus.irq_cause); end
    ack(); done();
    wr(1, 32'h0); pulse(5); pulse(2); wr(1, 32'h1FFFF); cycle();
    n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd2) begin n_fail++;
      $display("FAIL arb_both: req=%0b cause=%0d want 1/2", bus.irq_req, bus.irq_cause); end
    ack(); done(); cycle();
    n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd5) begin n_fail++;
      $display("FAIL arb_rest: req=%0b cause=%0d want 1/5", bus.irq_req, bus.irq_cause); end
    ack(); done();
  endtask

  task automatic test_mask();
    wr(1, 32'h0); pulse(4); cycle(); cycle();
    rd(0, rdata); n_cmp++; if (rdata !== 32'h10 || bus.irq_req !== 1'b0) begin n_fail++;
      $display("FAIL mask_block: pend=%h req=%0b want 10/0", rdata, bus.irq_req); end
    wr(1, 32'h10); cycle();
    n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd4) begin n_fail++;
      $display("FAIL mask_open: req=%0b cause=%0d want 1/4", bus.irq_req, bus.irq_cause); end
    wr(0, 32'h10); wr(1, 32'h0);
    rd(0, rdata); n_cmp++; if (rdata !== 32'h0 || bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd4) begin n_fail++;
      $display("FAIL mask_hold: pend=%h req=%0b cause=%0d want 0/1/4", rdata, bus.irq_req, bus.irq_cause); end
    ack();
    rd(2, rdata); n_cmp++; if (rdata !== 32'h24) begin n_fail++; $display("FAIL mask_status: got %h want 24", rdata); end
    done(); wr(1, 32'h1FFFF);
  endtask

  task automatic test_err();
    pulse(20); cycle(); cycle();
    rd(2, rdata); n_cmp++; if (rdata !== 32'h100 || bus.irq_req !== 1'b0) begin n_fail++;
      $display("FAIL err_set: status=%h req=%0b want 100/0", rdata, bus.irq_req); end
    wr(2, 32'h0);
    rd(2, rdata); n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL err_clear: got %h want 0", rdata); end
  endtask

  task automatic test_boundary();
    wr(1, 32'h0);
    bus.interrupt = 1'b1; bus.interrupt_id = 5'd7;
    bus.wEn = 1'b1; bus.addr = 32'h0; bus.dataIn = 32'h80;
    cycle();
    rd(0, rdata); n_cmp++; if (rdata !== 32'h80) begin n_fail++; $display("FAIL set_beats_w1c: got %h want 80", rdata); end
    pulse(16); pulse(0); pulse(17);
    rd(0, rdata); n_cmp++; if (rdata !== 32'h10081) begin n_fail++; $display("FAIL id_edges: got %h want 10081", rdata); end
    rd(2, rdata); n_cmp++; if (rdata !== 32'h100) begin n_fail++; $display("FAIL id17_err: got %h want 100", rdata); end
    wr(0, 32'h80); wr(1, 32'h1FFFF); cycle();
    n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd16) begin n_fail++;
      $display("FAIL id0_lowest: req=%0b cause=%0d want 1/16", bus.irq_req, bus.irq_cause); end
    ack(); done(); cycle();
    n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd0) begin n_fail++;
      $display("FAIL id0_req: req=%0b cause=%0d want 1/0", bus.irq_req, bus.irq_cause); end
    bus.irq_ack = 1'b1; bus.interrupt = 1'b1; bus.interrupt_id = 5'd0;
    cycle();
    rd(0, rdata); n_cmp++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL set_beats_ack: got %h want 1", rdata); end
    done(); cycle(); ack(); done(); wr(2, 32'h0);
  endtask

  task automatic test_nesting();
    pulse(6); cycle(); ack(); pulse(1); cycle();
    if (NEST) begin
      n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd1) begin n_fail++;
        $display("FAIL nest_req: req=%0b cause=%0d want 1/1", bus.irq_req, bus.irq_cause); end
      ack();
      rd(2, rdata); n_cmp++; if (rdata !== 32'h41) begin n_fail++; $display("FAIL nest_depth2: got %h want 41", rdata); end
      done();
      rd(2, rdata); n_cmp++; if (rdata !== 32'h26) begin n_fail++; $display("FAIL nest_pop: got %h want 26", rdata); end
      done();
    end else begin
      cycle(); cycle();
      rd(2, rdata); n_cmp++; if (bus.irq_req !== 1'b0 || rdata !== 32'h26) begin n_fail++;
        $display("FAIL flat_noreq: req=%0b status=%h want 0/26", bus.irq_req, rdata); end
      done(); cycle();
      n_cmp++; if (bus.irq_req !== 1'b1 || bus.irq_cause !== 5'd1) begin n_fail++;
        $display("FAIL flat_after: req=%0b cause=%0d want 1/1", bus.irq_req, bus.irq_cause); end
      ack(); done();
    end
    rd(2, rdata); n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL nest_end: got %h want 0", rdata); end
  endtask

  task automatic test_reset_mid();
    wr(1, 32'h200); pulse(9); pulse(3);
    n_cmp++; if (bus.irq_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: req=%0b want 1", bus.irq_req); end
    reset = 1'b1; cycle();
    rd(0, rdata); n_cmp++; if (rdata !== 32'h0 || bus.irq_req !== 1'b0 || bus.irq_cause !== 5'd0) begin n_fail++;
      $display("FAIL rmid_clear: pend=%h req=%0b cause=%0d want 0/0/0", rdata, bus.irq_req, bus.irq_cause); end
    rd(1, rdata); n_cmp++; if (rdata !== 32'h1FFFF) begin n_fail++; $display("FAIL rmid_mask: got %h want 1ffff", rdata); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      n_cmp++; if (bus.irq_req !== m_req || bus.irq_cause !== 5'(m_cause)) begin n_fail++;
        $display("FAIL rnd_req[%0d]: req=%0b cause=%0d want %0b/%0d", k, bus.irq_req, bus.irq_cause, m_req, m_cause); end
      rd(0, rdata); n_cmp++; if (rdata !== m_pend_word()) begin n_fail++;
        $display("FAIL rnd_pend[%0d]: got %h want %h", k, rdata, m_pend_word()); end
      rd(1, rdata); n_cmp++; if (rdata !== m_mask_word()) begin n_fail++;
        $display("FAIL rnd_mask[%0d]: got %h want %h", k, rdata, m_mask_word()); end
      rd(2, rdata); n_cmp++; if (rdata !== m_status()) begin n_fail++;
        $display("FAIL rnd_status[%0d]: got %h want %h", k, rdata, m_status()); end
      if ($urandom_range(0, 99) < 30) begin
        bus.interrupt = 1'b1; bus.interrupt_id = 5'($urandom_range(0, 20));
      end
      if (bus.irq_req) bus.irq_ack = ($urandom_range(0, 1) == 1);
      else             bus.irq_ack = ($urandom_range(0, 9) == 0);
      bus.irq_done = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.wEn    = 1'b1;
        bus.addr   = ($urandom() & 32'hFFFF_FFF3) | (32'($urandom_range(0, 3)) << 2);
        bus.dataIn = $urandom();
      end
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.interrupt = 1'b0; bus.interrupt_id = 5'd0; bus.wEn = 1'b0;
    bus.addr = 32'd0; bus.dataIn = 32'd0; bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
    test_reset();
    test_basic();
    test_arbitration();
    test_mask();
    test_err();
    test_boundary();
    test_nesting();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
